// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes,
// ALU/mux select values and the bundled control-word struct.
package multicycle_control_pkg;

    localparam int WAIT_W = 8;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ERR    = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic [1:0] pcsource;
        logic       instr_done;
        logic       err;
    } ctrl_t;

    // States that hold while waiting on memory and are covered by the timeout.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// Memory wait counter: counts consecutive not-ready cycles in a memory state
// and flags a timeout on the TIMEOUT_CYC-th such cycle.
module mcc_wait_timer
    import multicycle_control_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enter,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT_CYC - 1);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (enter || mem_ready || !active)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // cnt holds completed wait cycles, so the current one is cnt+1.
    assign timeout = active && !mem_ready && (cnt >= LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM (Moore, plus ready-qualified pcwrite/irwrite/instr_done).
// Optional jump support is enabled with `define MCC_JUMP_EN.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] aluop,
    output logic [1:0] pcsource,
    output logic       instr_done,
    output logic       err,
    output logic [3:0] state
);

    state_e st, nxt;
    ctrl_t  c;
    logic   timeout, enter;
    logic   unused_zero;

    // Branch resolution happens in the datapath via pcwritecond & zero.
    assign unused_zero = zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            st <= S_IDLE;
        else
            st <= nxt;
    end

    always_comb begin
        nxt = st;
        case (st)
            S_IDLE:   if (run) nxt = S_FETCH;
            S_FETCH:  if (mem_ready) nxt = S_DECODE;
                      else if (timeout) nxt = S_ERR;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
`ifdef MCC_JUMP_EN
                    OP_J:         nxt = S_JUMP;
`endif
                    default:      nxt = S_ERR;
                endcase
            end
            S_MEMADR: nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
                      else if (timeout) nxt = S_ERR;
            S_MEMWR:  if (mem_ready) nxt = run ? S_FETCH : S_IDLE;
                      else if (timeout) nxt = S_ERR;
            S_EXEC:   nxt = S_RWB;
`ifdef MCC_JUMP_EN
            S_JUMP,
`endif
            S_MEMWB, S_RWB, S_BRANCH: nxt = run ? S_FETCH : S_IDLE;
            S_ERR:    nxt = S_ERR;
            default:  nxt = S_ERR;
        endcase
    end

    assign enter = is_wait_state(nxt) && (nxt != st);

    mcc_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait (
        .clk       (clk),
        .rst_n     (rst_n),
        .enter     (enter),
        .active    (is_wait_state(st)),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_comb begin
        c = '0;
        case (st)
            S_FETCH: begin
                c.memread = 1'b1;
                c.alusrcb = SRCB_FOUR;
                c.aluop   = ALU_ADD;
                c.irwrite = mem_ready;
                c.pcwrite = mem_ready;
            end
            S_DECODE: begin
                c.alusrcb = SRCB_IMM_SH2;
                c.aluop   = ALU_ADD;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWR: begin
                c.memwrite   = 1'b1;
                c.iord       = 1'b1;
                c.instr_done = mem_ready;
            end
            S_MEMWB: begin
                c.regwrite   = 1'b1;
                c.memtoreg   = 1'b1;
                c.instr_done = 1'b1;
            end
            S_EXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REG;
                c.aluop   = ALU_FUNCT;
            end
            S_RWB: begin
                c.regwrite   = 1'b1;
                c.regdst     = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca     = 1'b1;
                c.aluop       = ALU_SUB;
                c.pcwritecond = 1'b1;
                c.pcsource    = PC_ALUOUT;
                c.instr_done  = 1'b1;
            end
`ifdef MCC_JUMP_EN
            S_JUMP: begin
                c.pcwrite    = 1'b1;
                c.pcsource   = PC_JUMP;
                c.instr_done = 1'b1;
            end
`endif
            S_ERR:   c.err = 1'b1;
            default: c = '0;
        endcase
    end

    assign pcwrite     = c.pcwrite;
    assign pcwritecond = c.pcwritecond;
    assign iord        = c.iord;
    assign memread     = c.memread;
    assign memwrite    = c.memwrite;
    assign irwrite     = c.irwrite;
    assign memtoreg    = c.memtoreg;
    assign regdst      = c.regdst;
    assign regwrite    = c.regwrite;
    assign alusrca     = c.alusrca;
    assign alusrcb     = c.alusrcb;
    assign aluop       = c.aluop;
    assign pcsource    = c.pcsource;
    assign instr_done  = c.instr_done;
    assign err         = c.err;
    assign state       = st;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: route-based instruction model checked every
// cycle, directed sequences with literal state pins, then randomized traffic.
module tb_multicycle_control;

    localparam int TMO = 15;

    logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = '0;
    logic pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg;
    logic regdst, regwrite, alusrca, instr_done, err;
    logic [1:0] alusrcb, pcsource;
    logic [2:0] aluop;
    logic [3:0] state;

    multicycle_control #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pcwrite(pcwrite), .pcwritecond(pcwritecond),
        .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource),
        .instr_done(instr_done), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit pin_en = 1'b0, pin_done = 1'b0;
    logic [3:0] pin_state = '0;

    // Model: current step code, remaining steps of the instruction, wait cycles.
    int m_cur = 0, m_wait = 0;
    int m_route[$];

    function automatic bit is_wait(input int c);
        return c == 1 || c == 4 || c == 6;
    endfunction

    function automatic bit m_done(input bit rdy);
        return m_route.size() == 0 && !(m_cur inside {0, 1, 2, 15}) &&
               (!is_wait(m_cur) || rdy);
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cur = 0; m_wait = 0; m_route.delete();
        end else if (m_cur == 15) begin
            m_cur = 15;
        end else if (m_cur == 0) begin
            if (run) m_cur = 1;
        end else if (is_wait(m_cur) && !mem_ready) begin
            m_wait++;
            if (m_wait >= TMO) begin m_cur = 15; m_wait = 0; m_route.delete(); end
        end else begin
            m_wait = 0;
            if (m_cur == 1) m_cur = 2;
            else begin
                if (m_cur == 2) begin
                    case (opcode)
                        6'b100011: m_route = '{3, 4, 5};
                        6'b101011: m_route = '{3, 6};
                        6'b000000: m_route = '{7, 8};
                        6'b000100: m_route = '{9};
`ifdef MCC_JUMP_EN
                        6'b000010: m_route = '{10};
`endif
                        default:   m_route.delete();
                    endcase
                end
                if (m_route.size() != 0) m_cur = m_route.pop_front();
                else if (m_cur == 2) m_cur = 15;
                else m_cur = run ? 1 : 0;
            end
        end
    end

    function automatic logic [22:0] exp_vec(input int c, input bit rdy, input bit done);
        bit pw, pwc, io, mr, mw, irw, mtr, rd, rw, asa, e;
        logic [1:0] b, p;
        logic [2:0] a;
        {pw, pwc, io, mr, mw, irw, mtr, rd, rw, asa, e} = '0;
        b = 2'b00; p = 2'b00; a = 3'b000;
        case (c)
            1:  begin mr = 1; b = 2'b01; pw = rdy; irw = rdy; end
            2:  b = 2'b11;
            3:  begin asa = 1; b = 2'b10; end
            4:  begin mr = 1; io = 1; end
            5:  begin rw = 1; mtr = 1; end
            6:  begin mw = 1; io = 1; end
            7:  begin asa = 1; a = 3'b010; end
            8:  begin rw = 1; rd = 1; end
            9:  begin asa = 1; a = 3'b001; pwc = 1; p = 2'b01; end
            10: begin pw = 1; p = 2'b10; end
            15: e = 1;
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, irw, mtr, rd, rw, asa, b, a, p, done, e, 4'(c)};
    endfunction

    always @(negedge clk) begin
        logic [22:0] act, req;
        act = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
               regdst, regwrite, alusrca, alusrcb, aluop, pcsource, instr_done, err, state};
        req = exp_vec(m_cur, mem_ready, m_done(mem_ready));
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL outs t=%0t actual=%h required=%h", $time, act, req);
        end
        if (pin_en) begin
            checks++;
            if (state !== pin_state || instr_done !== pin_done) begin
                errors++;
                $display("FAIL pin t=%0t actual state=%0d done=%0b required state=%0d done=%0b",
                         $time, state, instr_done, pin_state, pin_done);
            end
        end
    end

    task automatic step(input bit r_n, input bit rn, input logic [5:0] op, input bit rdy,
                        input bit pe, input logic [3:0] ps, input bit pd);
        @(posedge clk); #1;
        rst_n = r_n; run = rn; opcode = op; mem_ready = rdy;
        zero = 1'($urandom_range(0, 1));
        pin_en = pe; pin_state = ps; pin_done = pd;
    endtask

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BAD = 6'b111111;
    localparam logic [5:0] JOP = 6'b000010, BEQ = 6'b000100;

    initial begin
        int burst;
        logic [5:0] op;
        // R-type straight through with memory always ready
        step(0, 0, RT, 1, 1, 0, 0);
        step(1, 1, RT, 1, 1, 0, 0);
        step(1, 1, RT, 1, 1, 1, 0);
        step(1, 1, RT, 1, 1, 2, 0);
        step(1, 1, RT, 1, 1, 7, 0);
        step(1, 1, RT, 1, 1, 8, 1);
        // lw with three not-ready cycles in MEMRD
        step(1, 1, LW, 1, 1, 1, 0);
        step(1, 1, LW, 1, 1, 2, 0);
        step(1, 1, LW, 1, 1, 3, 0);
        for (int i = 0; i < 3; i++) step(1, 1, LW, 0, 1, 4, 0);
        step(1, 1, LW, 1, 1, 4, 0);
        step(1, 1, LW, 1, 1, 5, 1);
        // sw with run dropped at MEMADR: completes, then idles
        step(1, 1, SW, 1, 1, 1, 0);
        step(1, 1, SW, 1, 1, 2, 0);
        step(1, 0, SW, 1, 1, 3, 0);
        step(1, 0, SW, 0, 1, 6, 0);
        step(1, 0, SW, 1, 1, 6, 1);
        step(1, 0, SW, 0, 1, 0, 0);
        // illegal opcode
        step(1, 1, BAD, 1, 1, 0, 0);
        step(1, 1, BAD, 1, 1, 1, 0);
        step(1, 1, BAD, 1, 1, 2, 0);
        step(1, 1, BAD, 1, 1, 15, 0);
        step(1, 0, BAD, 1, 1, 15, 0);
        // reset taken in the middle of MEMRD
        step(0, 0, LW, 1, 1, 0, 0);
        step(1, 1, LW, 1, 1, 0, 0);
        step(1, 1, LW, 1, 1, 1, 0);
        step(1, 1, LW, 1, 1, 2, 0);
        step(1, 1, LW, 1, 1, 3, 0);
        step(1, 1, LW, 0, 1, 4, 0);
        step(0, 1, LW, 0, 1, 0, 0);
        // FETCH timeout: 15 wait cycles, then ERR which holds
        step(1, 1, RT, 0, 1, 0, 0);
        for (int i = 0; i < TMO; i++) step(1, 1, RT, 0, 1, 1, 0);
        step(1, 1, RT, 0, 1, 15, 0);
        step(1, 1, RT, 1, 1, 15, 0);
        step(1, 1, RT, 1, 1, 15, 0);
        // jump opcode
        step(0, 0, JOP, 1, 1, 0, 0);
        step(1, 1, JOP, 1, 1, 0, 0);
        step(1, 1, JOP, 1, 1, 1, 0);
        step(1, 1, JOP, 1, 1, 2, 0);
`ifdef MCC_JUMP_EN
        step(1, 0, JOP, 1, 1, 10, 1);
        step(1, 0, JOP, 1, 1, 0, 0);
`else
        step(1, 0, JOP, 1, 1, 15, 0);
        step(1, 0, JOP, 1, 1, 15, 0);
`endif
        // randomized traffic, recovering from ERR with a reset
        burst = 0;
        op = RT;
        for (int i = 0; i < 3000; i++) begin
            bit rb, rn, rdy;
            rb = !(m_cur == 15 && $urandom_range(0, 3) == 0);
            if (m_cur == 0 || m_cur == 1) begin
                case ($urandom_range(0, 15))
                    0, 1, 2, 3:  op = RT;
                    4, 5, 6, 7:  op = LW;
                    8, 9, 10:    op = SW;
                    11, 12:      op = BEQ;
                    13, 14:      op = JOP;
                    default:     op = 6'($urandom);
                endcase
            end
            if (burst == 0 && $urandom_range(0, 199) == 0) burst = TMO + 2;
            rdy = (burst == 0) && ($urandom_range(0, 3) != 0);
            if (burst > 0) burst--;
            rn = ($urandom_range(0, 7) != 0);
            step(rb, rn, op, rdy, 0, 0, 0);
        end
        @(posedge clk); #1;
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15, max cycles waiting for mem_ready in one memory state (range 1..255).
REQ-002 One clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 run  in  1  enable instruction sequencing; opcode  in  6  instruction[31:26] from instruction register; zero  in  1  ALU zero flag; mem_ready  in  1  memory access complete this cycle.
REQ-004 pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca  out  1 each  datapath strobes/selects.
REQ-005 alusrcb  out  2  (00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2); aluop  out  3  (000 add, 001 sub, 010 use funct); pcsource  out  2  (00 ALU, 01 ALUOut, 10 jump target).
REQ-006 instr_done  out  1  one-cycle pulse at the final cycle of each instruction; err  out  1  sticky fault flag; state  out  4  current state code.

Function
REQ-007 Moore FSM; all outputs except pcwrite/irwrite/instr_done SHALL be decoded from registered state only; unlisted outputs SHALL be 0.
REQ-008 States/codes: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, RWB 8, BRANCH 9, JUMP 10, ERR 15.
REQ-009 IDLE: all outputs 0; -> FETCH when run=1.
REQ-010 FETCH: memread=1, alusrcb=01, aluop=000; irwrite=pcwrite=mem_ready; -> DECODE on mem_ready, else stay.
REQ-011 DECODE: alusrcb=11, aluop=000; next by opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, other -> ERR.
REQ-012 MEMADR: alusrca=1, alusrcb=10; -> MEMRD if opcode=100011, else MEMWR.
REQ-013 MEMRD: memread=1, iord=1; -> MEMWB on mem_ready. MEMWR: memwrite=1, iord=1; -> FETCH/IDLE on mem_ready with instr_done.
REQ-014 MEMWB: regwrite=1, memtoreg=1, instr_done=1. EXEC: alusrca=1, aluop=010 -> RWB. RWB: regwrite=1, regdst=1, instr_done=1.
REQ-015 BRANCH: alusrca=1, aluop=001, pcwritecond=1, pcsource=01, instr_done=1. JUMP: pcwrite=1, pcsource=10, instr_done=1.
REQ-016 Every instr_done state SHALL go to FETCH if run=1, else IDLE; run deassertion mid-instruction SHALL NOT abort it.
REQ-017 8-bit wait counter SHALL clear on entering FETCH/MEMRD/MEMWR and on mem_ready, increment each cycle in those states with mem_ready=0; reaching TIMEOUT_CYC -> ERR.
REQ-018 mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored.
REQ-019 ERR: err=1, all other outputs 0, state held until reset.

Reset
REQ-020 rst_n low SHALL force state=IDLE, counter=0, err=0, all outputs 0 immediately, including mid-access.
REQ-021 First possible FETCH is the first clk edge after rst_n release with run=1.

Configuration
REQ-022 Macro MCC_JUMP_EN: defined -> opcode 000010 sequences DECODE->JUMP; undefined -> JUMP state absent, pcsource never 10, opcode 000010 -> ERR.

Structure
REQ-023 Shared package holds state enum, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J), aluop and alusrcb/pcsource encodings.
REQ-024 One sub-module mcc_wait_timer (wait counter + timeout compare); FSM and output decode stay in multicycle_control.

Verification
REQ-025 R-type (000000), run=1, mem_ready=1 every cycle -> FETCH,DECODE,EXEC,RWB; instr_done on cycle 4; regwrite=regdst=1 in RWB.
REQ-026 lw (100011), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, memread=iord=1 throughout, then MEMWB with memtoreg=regwrite=1.
REQ-027 FETCH with mem_ready stuck 0, TIMEOUT_CYC=15 -> ERR after 15 wait cycles; err=1 and stays until rst_n.
REQ-028 Opcode 111111 in DECODE -> ERR next cycle; with MCC_JUMP_EN undefined, opcode 000010 -> ERR.
REQ-029 run dropped during sw MEMADR -> MEMWR completes, instr_done pulses, then IDLE with all outputs 0.
REQ-030 rst_n asserted in MEMRD -> same cycle state=0, memread=0, err=0.
